// File: rtl/fifo_rdport_if.sv
// Valid/ready word stream leaving the FIFO read side.
// The master presents words; the slave accepts them with ready.
interface fifo_rdport_if #(
  parameter int DATASIZE = 8
) ();

  logic                valid;
  logic [DATASIZE-1:0] data;
  logic                ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/fifo_rdport.sv
// FIFO read-side controller: owns rptr, hides the registered memory read
// and presents stored words as a first-word-fall-through stream.
module fifo_rdport #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] raddr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  fifo_rdport_if.master       m
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [ADDRSIZE:0] PTR_ONE = 1;

  state_t              state;
  logic [DATASIZE-1:0] head;
  logic [DATASIZE-1:0] skid;
  logic                valid;
  logic                infl;
  logic [ADDRSIZE:0]   rptr_q;

  logic                pop;
  logic                issue;
  logic [1:0]          occ;
  logic [2:0]          lvl;

  assign occ    = state;
  assign pop    = valid && m.ready;
  assign rempty = (rptr_q == wptr);

  // Words held or arriving after this cycle's pop; must stay below 2.
  assign lvl   = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign issue = !rempty && (lvl < 3'd2);

  assign rptr    = rptr_q;
  assign raddr   = rptr_q[ADDRSIZE-1:0];
  assign m.valid = valid;
  assign m.data  = head;

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      infl   <= 1'b0;
      state  <= EMPTY;
      head   <= '0;
      skid   <= '0;
      valid  <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
      unique case (state)
        EMPTY: begin
          if (infl) begin
            head  <= rdata;
            valid <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (infl && !pop) begin
            skid  <= rdata;
            state <= TWO;
          end else if (infl && pop) begin
            head <= rdata;
          end else if (pop) begin
            valid <= 1'b0;
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head <= skid;
            if (infl) begin
              skid <= rdata;
            end else begin
              state <= ONE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= EMPTY;
        end
      endcase
    end
  end

  // A full buffer can never receive an arrival without draining one word.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
      !(state == TWO && infl && !pop)
  );

endmodule

// File: tb/tb_fifo_rdport.sv
// Self-checking bench for fifo_rdport with a memory/writer model
// and an in-order scoreboard fed by the writer.
module tb_fifo_rdport;

  localparam int DS = 8;
  localparam int AS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AS:0]   wptr;
  logic [AS-1:0] raddr;
  logic [DS-1:0] rdata;
  logic [AS:0]   rptr;
  logic          rempty;

  logic          wr_en = 1'b0;
  logic [DS-1:0] wr_data = '0;
  logic [DS-1:0] mem [0:(1<<AS)-1];

  fifo_rdport_if #(.DATASIZE(DS)) m_if ();

  fifo_rdport #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
    .clk   (clk),
    .rst   (rst),
    .wptr  (wptr),
    .raddr (raddr),
    .rdata (rdata),
    .rptr  (rptr),
    .rempty(rempty),
    .m     (m_if.master)
  );

  always #5 clk = ~clk;

  // Writer and memory: wptr moves on the same edge as the write.
  always @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
    end else if (wr_en) begin
      mem[wptr[AS-1:0]] <= wr_data;
      wptr <= wptr + 1'b1;
    end
    rdata <= mem[raddr];
  end

  int errors = 0;
  int checks = 0;
  int npop   = 0;
  logic [DS-1:0] q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_if.valid && m_if.ready) begin
      npop++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got 0x%0h expected none", m_if.data);
      end else begin
        check("sb_data", int'(m_if.data), int'(q.pop_front()));
      end
    end
  end

  logic [AS:0] used;
  assign used = wptr - rptr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic write_word(input logic [DS-1:0] d);
    int g = 0;
    while (used[AS] && g < 200) begin
      tick();
      g++;
    end
    if (g >= 200) check("wr_timeout", 1, 0);
    wr_en = 1'b1;
    wr_data = d;
    q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g = 0;
    m_if.ready = 1'b1;
    while ((q.size() != 0 || m_if.valid) && g < budget) begin
      tick();
      g++;
    end
    check("drain_done", int'(g < budget), 1);
  endtask

  initial begin
    int p0;
    int sent;
    int guard;
    m_if.ready = 1'b0;
    tick();
    do_reset();

    check("rst_valid", int'(m_if.valid), 0);
    check("rst_rptr", int'(rptr), 0);
    check("rst_rempty", int'(rempty), 1);
    repeat (20) tick();
    check("idle_rptr", int'(rptr), 0);
    check("idle_valid", int'(m_if.valid), 0);

    // Single word latency
    m_if.ready = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hA5;
    q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("lat_t_valid", int'(m_if.valid), 0);
    check("lat_t_rempty", int'(rempty), 0);
    tick();
    check("lat_t1_rptr", int'(rptr), 1);
    check("lat_t1_valid", int'(m_if.valid), 0);
    tick();
    check("lat_t2_valid", int'(m_if.valid), 1);
    check("lat_t2_data", int'(m_if.data), 'hA5);
    tick();
    check("lat_pop_valid", int'(m_if.valid), 0);
    check("lat_pop_rptr", int'(rptr), 1);
    check("lat_pop_rempty", int'(rempty), 1);

    // Prefill a full memory, then stream
    do_reset();
    m_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(i[DS-1:0]);
    check("pre_wptr", int'(wptr), 16);
    p0 = npop;
    m_if.ready = 1'b1;
    repeat (16) tick();
    check("pre_burst", npop - p0, 16);
    drain(50);
    check("pre_rptr", int'(rptr), 16);
    check("pre_raddr", int'(raddr), 0);
    for (int i = 16; i < 32; i++) write_word(i[DS-1:0]);
    drain(50);
    check("wrap_rptr", int'(rptr), 0);
    check("wrap_rempty", int'(rempty), 1);

    // Backpressure
    do_reset();
    m_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(8'h80 + i[DS-1:0]);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", int'(m_if.data), 'h80);
    end
    check("bp_valid", int'(m_if.valid), 1);
    check("bp_rptr", int'(rptr), 2);
    check("bp_occ", int'(dut.state), 2);
    p0 = npop;
    m_if.ready = 1'b1;
    repeat (8) tick();
    check("bp_burst", npop - p0, 8);
    drain(20);

    // Random writer against random ready
    sent = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      m_if.ready = 1'($urandom_range(0, 1));
      if (!used[AS] && $urandom_range(0, 1) == 1) begin
        wr_en = 1'b1;
        wr_data = DS'($urandom);
        q.push_back(wr_data);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    wr_en = 1'b0;
    check("rnd_sent", sent, 10000);
    drain(200);
    check("rnd_sb_empty", q.size(), 0);

    // Reset while the buffer is full
    m_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(8'h50 + i[DS-1:0]);
    check("mid_occ", int'(dut.state), 2);
    do_reset();
    check("mid_valid", int'(m_if.valid), 0);
    check("mid_rptr", int'(rptr), 0);
    check("mid_rempty", int'(rempty), 1);
    p0 = npop;
    m_if.ready = 1'b1;
    write_word(8'h3C);
    drain(20);
    check("mid_first_cnt", npop - p0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
